// File: rtl/me_unit_pkg.sv
// Shared definitions for the ME pipeline stage: bus widths, bus field offsets,
// load opcodes and the stage state encoding.
package me_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int EX_ME_W = 74;
  localparam int ME_WB_W = 70;
  localparam int ME_ID_W = 39;

  // EX_to_ME_Bus field positions
  localparam int EX_PC_LSB   = 42;
  localparam int EX_WE_BIT   = 41;
  localparam int EX_DEST_LSB = 36;
  localparam int EX_MEM_BIT  = 35;
  localparam int EX_OP_LSB   = 32;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_DONE      = 2'd2
  } me_state_e;

endpackage

// File: rtl/me_unit_if.sv
// Handshake and data buses around the ME stage: EX->ME, data SRAM response,
// ME->WB and the ME forwarding bus to ID.
interface me_unit_if
  import me_unit_pkg::*;
();

  logic               EX_Valid;
  logic               ME_Allowin;
  logic [EX_ME_W-1:0] EX_to_ME_Bus;
  logic               data_sram_data_ok;
  logic [DATA_W-1:0]  data_sram_rdata;
  logic               ME_Valid;
  logic               WB_Allowin;
  logic [ME_WB_W-1:0] ME_to_WB_Bus;
  logic [ME_ID_W-1:0] ME_to_ID_Bus;

  modport slave (
    input  EX_Valid, EX_to_ME_Bus, data_sram_data_ok, data_sram_rdata, WB_Allowin,
    output ME_Allowin, ME_Valid, ME_to_WB_Bus, ME_to_ID_Bus
  );

  modport master (
    output EX_Valid, EX_to_ME_Bus, data_sram_data_ok, data_sram_rdata, WB_Allowin,
    input  ME_Allowin, ME_Valid, ME_to_WB_Bus, ME_to_ID_Bus
  );

endinterface

// File: rtl/me_unit_load_align.sv
// Load data alignment: picks the addressed byte/half out of a word-aligned read
// and sign- or zero-extends it to 32 bits.
module me_unit_load_align
  import me_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_load_op,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // off[0] is ignored for halves; misaligned halves never reach this stage
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_result = i_rdata;
    case (i_load_op)
      LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_result = {24'd0, w_byte};
      LD_H:    o_result = {{16{w_half[15]}}, w_half};
      LD_HU:   o_result = {16'd0, w_half};
      LD_W:    o_result = i_rdata;
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/me_unit.sv
// ME stage: latches EX results, waits for load data, forwards the final result
// to WB and publishes forwarding/load-pending status to ID.
//
// state        | meaning
// ST_EMPTY     | no instruction held
// ST_WAIT_DATA | load held, waiting for data_sram_data_ok
// ST_DONE      | result ready, presented to WB
module me_unit
  import me_unit_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  me_unit_if.slave bus
);

  me_state_e   r_state;
  me_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic        r_gr_we;
  logic [4:0]  r_dest;
  logic [2:0]  r_load_op;
  logic [1:0]  r_off;
  logic [31:0] r_result;

  logic        w_allowin;
  logic        w_accept;
  logic        w_ex_load;
  logic        w_data_take;
  logic        w_fwd_we;
  logic [31:0] w_load_data;

  assign w_allowin   = (r_state == ST_EMPTY) || ((r_state == ST_DONE) && bus.WB_Allowin);
  assign w_accept    = bus.EX_Valid && w_allowin;
  assign w_ex_load   = bus.EX_to_ME_Bus[EX_MEM_BIT];
  assign w_data_take = (r_state == ST_WAIT_DATA) && bus.data_sram_data_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_nxt = w_ex_load ? ST_WAIT_DATA : ST_DONE;
      end
      ST_WAIT_DATA: begin
        if (bus.data_sram_data_ok) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.WB_Allowin) begin
          if (w_accept) w_state_nxt = w_ex_load ? ST_WAIT_DATA : ST_DONE;
          else          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  me_unit_load_align u_load_align (
    .i_rdata   (bus.data_sram_rdata),
    .i_off     (r_off),
    .i_load_op (r_load_op),
    .o_result  (w_load_data)
  );

  // Result register is the only path to WB; rdata is never passed through combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= '0;
      r_gr_we   <= 1'b0;
      r_dest    <= '0;
      r_load_op <= '0;
      r_off     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_pc      <= bus.EX_to_ME_Bus[EX_PC_LSB +: 32];
      r_gr_we   <= bus.EX_to_ME_Bus[EX_WE_BIT];
      r_dest    <= bus.EX_to_ME_Bus[EX_DEST_LSB +: 5];
      r_load_op <= bus.EX_to_ME_Bus[EX_OP_LSB +: 3];
      r_off     <= bus.EX_to_ME_Bus[1:0];
      r_result  <= bus.EX_to_ME_Bus[31:0];
    end else if (w_data_take) begin
      r_result  <= w_load_data;
    end
  end

  assign w_fwd_we = r_gr_we && (r_state != ST_EMPTY) && (r_dest != 5'd0);

  assign bus.ME_Allowin   = w_allowin;
  assign bus.ME_Valid     = (r_state == ST_DONE);
  assign bus.ME_to_WB_Bus = {r_pc, r_gr_we, r_dest, r_result};
  assign bus.ME_to_ID_Bus = {w_fwd_we, r_dest, r_result, (r_state == ST_WAIT_DATA)};

endmodule

// File: tb/tb_me_unit.sv
// Bench for me_unit: directed cases followed by random traffic, all checked
// against a transaction-level model of the stage's occupancy and results.
module tb_me_unit;

  localparam logic [2:0] T_LD_B = 3'd0, T_LD_H = 3'd1, T_LD_W = 3'd2, T_LD_BU = 3'd3, T_LD_HU = 3'd4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  me_unit_if bif ();

  me_unit u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus for the next cycle
  bit          drv_ex_valid;
  logic [31:0] drv_pc;
  bit          drv_we;
  logic [4:0]  drv_dest;
  bit          drv_load;
  logic [2:0]  drv_op;
  logic [31:0] drv_alu;
  logic [31:0] drv_word;
  int          drv_delay;
  bit          drv_wb;

  // model: what the stage holds, whether its result is ready, and the expected WB word
  bit          m_have;
  bit          m_ready;
  logic [69:0] m_item;
  logic [31:0] m_rdata;
  logic [1:0]  m_off;
  logic [2:0]  m_op;
  int          m_cnt;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] op);
    logic [31:0] v;
    v = w;
    if (op == T_LD_B || op == T_LD_BU) begin
      v = (w >> (8 * off)) & 32'h0000_00FF;
      if (op == T_LD_B && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (op == T_LD_H || op == T_LD_HU) begin
      v = (w >> (16 * off[1])) & 32'h0000_FFFF;
      if (op == T_LD_H && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One clock: drive inputs, check outputs against the model, clock, update model.
  task automatic cycle();
    bit exp_allow;
    bit dok;
    dok = m_have && !m_ready && (m_cnt == 0);
    bif.EX_Valid          = drv_ex_valid;
    bif.EX_to_ME_Bus      = {drv_pc, drv_we, drv_dest, drv_load, drv_op, drv_alu};
    bif.WB_Allowin        = drv_wb;
    bif.data_sram_data_ok = dok;
    bif.data_sram_rdata   = dok ? m_rdata : $urandom;
    #2;
    exp_allow = !m_have || (m_ready && drv_wb);
    chk("allowin", 70'(bif.ME_Allowin), 70'(exp_allow));
    chk("me_valid", 70'(bif.ME_Valid), 70'(m_have && m_ready));
    if (m_have && m_ready) begin
      chk("wb_bus", bif.ME_to_WB_Bus, m_item);
      chk("fwd_data", 70'(bif.ME_to_ID_Bus[32:1]), 70'(m_item[31:0]));
    end
    chk("fwd_we", 70'(bif.ME_to_ID_Bus[38]), 70'(m_have && m_item[37] && (m_item[36:32] != 5'd0)));
    chk("load_pending", 70'(bif.ME_to_ID_Bus[0]), 70'(m_have && !m_ready));
    if (m_have) chk("fwd_dest", 70'(bif.ME_to_ID_Bus[37:33]), 70'(m_item[36:32]));
    @(posedge clk);
    if (m_have && m_ready && drv_wb) begin
      m_have = 1'b0;
    end else if (m_have && !m_ready) begin
      if (dok) begin
        m_ready       = 1'b1;
        m_item[31:0]  = ref_load(m_rdata, m_off, m_op);
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
    end
    if (drv_ex_valid && exp_allow) begin
      m_have  = 1'b1;
      m_ready = !drv_load;
      m_item  = {drv_pc, drv_we, drv_dest, drv_alu};
      m_rdata = drv_word;
      m_off   = drv_alu[1:0];
      m_op    = drv_op;
      m_cnt   = drv_delay - 1;
    end
    #1;
  endtask

  task automatic set_alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] alu);
    drv_ex_valid = 1'b1; drv_pc = pc; drv_we = 1'b1; drv_dest = dest;
    drv_load = 1'b0; drv_op = T_LD_W; drv_alu = alu; drv_delay = 1;
  endtask

  // Issue one load, data_ok `delay` cycles after accept, and check the fixed expectations.
  task automatic run_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] word,
                          input logic [4:0] dest, input int delay, input bit exp_fwd_we,
                          input logic [31:0] exp_res);
    drv_ex_valid = 1'b1; drv_pc = 32'h1C00_0100 + 32'(op); drv_we = 1'b1; drv_dest = dest;
    drv_load = 1'b1; drv_op = op; drv_alu = {30'h0000_0400, off}; drv_word = word;
    drv_delay = delay; drv_wb = 1'b1;
    cycle();
    drv_ex_valid = 1'b0;
    chk("ld_allowin_wait", 70'(bif.ME_Allowin), 70'(1'b0));
    chk("ld_id_pending", 70'({bif.ME_to_ID_Bus[38:33], bif.ME_to_ID_Bus[0]}),
        70'({exp_fwd_we, dest, 1'b1}));
    for (int i = 0; i < delay; i++) cycle();
    chk("ld_result", 70'(bif.ME_to_WB_Bus[31:0]), 70'(exp_res));
    chk("ld_id_done", 70'({bif.ME_to_ID_Bus[38:33], bif.ME_to_ID_Bus[32:1], bif.ME_to_ID_Bus[0]}),
        70'({exp_fwd_we, dest, exp_res, 1'b0}));
    cycle();
  endtask

  initial begin
    m_have = 1'b0; m_ready = 1'b0; m_item = '0; m_rdata = '0; m_off = '0; m_op = '0; m_cnt = 0;
    drv_ex_valid = 1'b0; drv_pc = '0; drv_we = 1'b0; drv_dest = '0; drv_load = 1'b0;
    drv_op = '0; drv_alu = '0; drv_word = '0; drv_delay = 1; drv_wb = 1'b1;
    bif.EX_Valid = 1'b0; bif.EX_to_ME_Bus = '0; bif.data_sram_data_ok = 1'b0;
    bif.data_sram_rdata = '0; bif.WB_Allowin = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_me_valid", 70'(bif.ME_Valid), 70'(1'b0));
    chk("rst_allowin", 70'(bif.ME_Allowin), 70'(1'b1));
    chk("rst_id_bus", 70'(bif.ME_to_ID_Bus), 70'(0));
    chk("rst_wb_bus", bif.ME_to_WB_Bus, 70'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // single ALU op
    set_alu(32'h1C00_0000, 5'd5, 32'h1234_5678); drv_wb = 1'b1;
    cycle();
    drv_ex_valid = 1'b0;
    chk("alu_valid", 70'(bif.ME_Valid), 70'(1'b1));
    chk("alu_bus", bif.ME_to_WB_Bus, {32'h1C00_0000, 1'b1, 5'd5, 32'h1234_5678});
    cycle();

    // loads
    run_load(T_LD_B,  2'd3, 32'h80FF_7F01, 5'd6, 2, 1'b1, 32'hFFFF_FF80);
    run_load(T_LD_HU, 2'd2, 32'hBEEF_1234, 5'd8, 1, 1'b1, 32'h0000_BEEF);
    run_load(T_LD_H,  2'd2, 32'hBEEF_1234, 5'd9, 1, 1'b1, 32'hFFFF_BEEF);
    run_load(T_LD_W,  2'd0, 32'hBEEF_1234, 5'd7, 3, 1'b1, 32'hBEEF_1234);
    run_load(T_LD_BU, 2'd1, 32'h1234_A5C3, 5'd0, 2, 1'b0, 32'h0000_00A5);

    // back-to-back ALU ops with WB stalling for one cycle
    set_alu(32'h1C00_0200, 5'd1, 32'hAAAA_0001); drv_wb = 1'b1;
    cycle();
    set_alu(32'h1C00_0204, 5'd2, 32'hAAAA_0002); drv_wb = 1'b0;
    cycle();
    chk("held_pc", 70'(bif.ME_to_WB_Bus[69:38]), 70'(32'h1C00_0200));
    chk("held_res", 70'(bif.ME_to_WB_Bus[31:0]), 70'(32'hAAAA_0001));
    drv_wb = 1'b1;
    cycle();
    chk("b2b_pc1", 70'(bif.ME_to_WB_Bus[69:38]), 70'(32'h1C00_0204));
    set_alu(32'h1C00_0208, 5'd3, 32'hAAAA_0003);
    cycle();
    chk("b2b_pc2", 70'(bif.ME_to_WB_Bus[69:38]), 70'(32'h1C00_0208));
    drv_ex_valid = 1'b0;
    cycle();

    // reset while a load waits for its data
    drv_ex_valid = 1'b1; drv_pc = 32'h1C00_0300; drv_we = 1'b1; drv_dest = 5'd7;
    drv_load = 1'b1; drv_op = T_LD_W; drv_alu = 32'h0000_2000; drv_word = 32'h5555_AAAA;
    drv_delay = 3;
    cycle();
    drv_ex_valid = 1'b0;
    cycle();
    resetn = 1'b0;
    #1;
    chk("rstw_me_valid", 70'(bif.ME_Valid), 70'(1'b0));
    chk("rstw_allowin", 70'(bif.ME_Allowin), 70'(1'b1));
    chk("rstw_id_bus", 70'(bif.ME_to_ID_Bus), 70'(0));
    m_have = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    bif.EX_Valid = 1'b0; bif.data_sram_data_ok = 1'b1; bif.data_sram_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bif.data_sram_data_ok = 1'b0;
    chk("stale_dok_valid", 70'(bif.ME_Valid), 70'(1'b0));
    chk("stale_dok_allowin", 70'(bif.ME_Allowin), 70'(1'b1));
    chk("stale_dok_pending", 70'(bif.ME_to_ID_Bus[0]), 70'(1'b0));
    cycle();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      drv_ex_valid = ($urandom_range(0, 3) != 0);
      drv_pc       = $urandom;
      drv_we       = ($urandom_range(0, 1) == 1);
      drv_dest     = 5'($urandom);
      drv_load     = ($urandom_range(0, 1) == 1);
      drv_op       = 3'($urandom_range(0, 4));
      drv_alu      = $urandom;
      drv_word     = $urandom;
      drv_delay    = $urandom_range(1, 3);
      drv_wb       = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drv_ex_valid = 1'b0; drv_wb = 1'b1;
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
